// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input truth-table sweeper: drives all 16 vectors onto {d,c,b,a},
// samples f_in after a settle delay, and scores the captured table against EXPECTED.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED      = 16'h77FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  cnt_q;
  logic [3:0]  vec_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] table_q;
  logic        pass_q;
  logic [4:0]  err_q;
  logic [3:0]  ffi_q;

  // Working copy of the sweep in progress; results only publish on DONE entry.
  logic [15:0] shadow_q, shadow_d;
  logic [4:0]  tally_q, tally_d;
  logic [3:0]  first_q, first_d;
  logic        mismatch;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mismatch = (f_in != EXPECTED[idx_q]);
    shadow_d = shadow_q;
    shadow_d[idx_q] = f_in;
    tally_d  = tally_q + {4'd0, mismatch};
    first_d  = (mismatch && (tally_q == 5'd0)) ? idx_q : first_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the shadow table is deliberately left out of reset; it is cleared
      // whenever a sweep is accepted and is never observable before that.
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffi_q   <= '0;
      tally_q <= '0;
      first_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q  <= SETTLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b1;
            shadow_q <= '0;
            tally_q  <= '0;
            first_q  <= '0;
          end
        end

        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        SAMPLE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
          end else begin
            shadow_q <= shadow_d;
            tally_q  <= tally_d;
            first_q  <= first_d;
            if (idx_q == 4'd15) begin
              // Final sample folds straight into the published results.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              vec_q   <= '0;
              table_q <= shadow_d;
              err_q   <= tally_d;
              ffi_q   <= first_d;
              pass_q  <= (tally_d == 5'd0);
            end else begin
              state_q <= SETTLE;
              idx_q   <= idx_q + 4'd1;
              vec_q   <= idx_q + 4'd1;
              cnt_q   <= '0;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign {d, c, b, a}   = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = table_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance at SETTLE_CYCLES=1 fed by a
// formula model or a lookup pattern, a second at SETTLE_CYCLES=3 fed by the model.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, start3;
  logic        use_model;
  logic [15:0] pattern;

  logic        a, b, c, d, busy, done, pass, f_in;
  logic [15:0] table_out;
  logic [4:0]  err_count;
  logic [3:0]  first_fail_idx;

  logic        a3, b3, c3, d3, busy3, done3, pass3, f_in3;
  logic [15:0] table_out3;
  logic [4:0]  err_count3;
  logic [3:0]  first_fail_idx3;

  int checks = 0;
  int errors = 0;

  function automatic logic ref_f(input logic a_, input logic b_, input logic c_, input logic d_);
    return (a_ ^ b_) | (~a_ & c_) | ~(b_ & d_);
  endfunction

  logic [3:0] vec, vec3;
  assign vec  = {d, c, b, a};
  assign vec3 = {d3, c3, b3, a3};
  assign f_in  = use_model ? ref_f(a, b, c, d) : pattern[vec];
  assign f_in3 = ref_f(a3, b3, c3, d3);

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'h77FF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .table_out(table_out), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(3), .EXPECTED(16'h77FF)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .f_in(f_in3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
    .table_out(table_out3), .pass(pass3), .err_count(err_count3),
    .first_fail_idx(first_fail_idx3)
  );

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start3 = 1'b0;
    use_model = 1'b1; pattern = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (vec !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: vec=%h busy=%b done=%b, want 0 0 0", vec, busy, done);
    end
    checks++;
    if (table_out !== 16'h0000 || err_count !== 5'd0 || first_fail_idx !== 4'd0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_results: table=%h err=%0d ffi=%0d pass=%b, want 0 0 0 0",
               table_out, err_count, first_fail_idx, pass);
    end
    checks++;
    if ({vec3, busy3, done3, table_out3, err_count3, first_fail_idx3, pass3} !== '0) begin
      errors++;
      $display("FAIL reset_dut3: vec=%h busy=%b done=%b table=%h, want all zero",
               vec3, busy3, done3, table_out3);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string name, input bit mdl, input logic [15:0] pat,
                       input logic [15:0] exp_tab, input logic [4:0] exp_err,
                       input logic [3:0] exp_ffi, input int r1, input int r2,
                       input bit start_in_done);
    int k;
    int bad;
    int late;
    use_model = mdl; pattern = pat; bad = 0; late = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      if (vec !== 4'(k / 2) || busy !== 1'b1) bad++;
      start = (k == r1 || k == r2);
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    checks++;
    if (k != 32 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: done after %0d cycles (done=%b), want 32", name, k, done);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s vectors: %0d bad vector/busy cycles, want 0", name, bad);
    end
    checks++;
    if (table_out !== exp_tab) begin
      errors++;
      $display("FAIL %s table: got %h, want %h", name, table_out, exp_tab);
    end
    checks++;
    if (err_count !== exp_err || first_fail_idx !== exp_ffi || pass !== (exp_err == 5'd0)) begin
      errors++;
      $display("FAIL %s score: err=%0d ffi=%0d pass=%b, want err=%0d ffi=%0d pass=%b",
               name, err_count, first_fail_idx, pass, exp_err, exp_ffi, exp_err == 5'd0);
    end
    checks++;
    if (busy !== 1'b0 || vec !== 4'd0) begin
      errors++;
      $display("FAIL %s done_state: busy=%b vec=%h, want 0 0", name, busy, vec);
    end
    start = start_in_done;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) late++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL %s after_done: %0d cycles with busy/done set, want 0", name, late);
    end
  endtask

  task automatic test_abort();
    int k;
    int hits;
    use_model = 1'b0; pattern = 16'h0000; hits = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (vec !== 4'd5 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (vec !== 4'd5) begin
      errors++;
      $display("FAIL abort_reach: vec=%h, want 5", vec);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || vec !== 4'd0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b vec=%h, want 0 0", busy, vec);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d cycles with busy/done, want 0", hits);
    end
    checks++;
    if (table_out !== 16'hFFFF || err_count !== 5'd2 || pass !== 1'b0 || first_fail_idx !== 4'd11) begin
      errors++;
      $display("FAIL abort_hold: table=%h err=%0d pass=%b ffi=%0d, want FFFF 2 0 11",
               table_out, err_count, pass, first_fail_idx);
    end
  endtask

  task automatic test_start_abort_idle();
    int hits;
    hits = 0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) hits++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL start_abort_idle: %0d cycles with busy/done, want 0", hits);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int hits;
    use_model = 1'b1; hits = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (vec !== 4'd9 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (vec !== 4'd9) begin
      errors++;
      $display("FAIL rstmid_reach: vec=%h, want 9", vec);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if ({vec, busy, done, table_out, err_count, first_fail_idx, pass} !== '0) begin
      errors++;
      $display("FAIL rstmid_state: vec=%h busy=%b done=%b table=%h err=%0d ffi=%0d pass=%b, want all 0",
               vec, busy, done, table_out, err_count, first_fail_idx, pass);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: %0d cycles with busy/done, want 0", hits);
    end
    sweep("after_reset", 1'b1, 16'h0000, 16'h77FF, 5'd0, 4'd0, -1, -1, 1'b0);
  endtask

  task automatic test_settle3();
    int k;
    int bad;
    bad = 0;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    k = 0;
    while (done3 !== 1'b1 && k < 200) begin
      if (vec3 !== 4'(k / 4) || busy3 !== 1'b1) bad++;
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k != 64 || done3 !== 1'b1) begin
      errors++;
      $display("FAIL settle3_latency: done after %0d cycles (done=%b), want 64", k, done3);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL settle3_vectors: %0d bad vector/busy cycles, want 0", bad);
    end
    checks++;
    if (table_out3 !== 16'h77FF || pass3 !== 1'b1 || err_count3 !== 5'd0 || first_fail_idx3 !== 4'd0) begin
      errors++;
      $display("FAIL settle3_result: table=%h pass=%b err=%0d ffi=%0d, want 77FF 1 0 0",
               table_out3, pass3, err_count3, first_fail_idx3);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done3 !== 1'b0 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL settle3_pulse: done=%b busy=%b, want 0 0", done3, busy3);
    end
  endtask

  initial begin
    test_reset();
    sweep("model",     1'b1, 16'h0000, 16'h77FF, 5'd0,  4'd0,  -1, -1, 1'b0);
    sweep("all_ones",  1'b0, 16'hFFFF, 16'hFFFF, 5'd2,  4'd11, -1, -1, 1'b0);
    sweep("all_zeros", 1'b0, 16'h0000, 16'h0000, 5'd14, 4'd0,  -1, -1, 1'b0);
    sweep("bit15",     1'b0, 16'hF7FF, 16'hF7FF, 5'd1,  4'd15, -1, -1, 1'b1);
    sweep("bit13",     1'b0, 16'h57FF, 16'h57FF, 5'd1,  4'd13, -1, -1, 1'b0);
    sweep("bit0",      1'b0, 16'h77FE, 16'h77FE, 5'd1,  4'd0,  -1, -1, 1'b0);
    sweep("inverted",  1'b0, 16'h8800, 16'h8800, 5'd16, 4'd0,  -1, -1, 1'b0);
    sweep("restart",   1'b1, 16'h0000, 16'h77FF, 5'd0,  4'd0,   5, 20, 1'b0);
    sweep("prior",     1'b0, 16'hFFFF, 16'hFFFF, 5'd2,  4'd11, -1, -1, 1'b0);
    test_abort();
    test_start_abort_idle();
    test_reset_mid();
    test_settle3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
